// File: rtl/gpio_irq_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : gpio_irq_sequencer
// Description : Avalon-MM master that owns a five-register GPIO slave.
//               Programs it after reset and on request, forwards output
//               writes, services the interrupt (capture, re-arm, ack) and
//               buffers captured input events in a FWFT FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_irq_sequencer #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter logic [31:0] ENABLE_INIT = 32'h0,
    parameter logic [31:0] MASK_INIT   = 32'h0,
    parameter logic [31:0] POOL_INIT   = 32'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        avm_write,
    output logic        avm_read,
    output logic [4:0]  avm_address,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        gpio_irq,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [31:0] cfg_enable,
    input  logic [31:0] cfg_mask,
    input  logic        out_valid,
    output logic        out_ready,
    input  logic [31:0] out_data,
    output logic        ev_valid,
    input  logic        ev_ready,
    output logic [31:0] ev_data,
    output logic [31:0] ev_changed,
    output logic        ev_overflow,
    input  logic        ovf_clr
);

    localparam int unsigned     c_PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [c_PTR_W:0] c_PTR_ONE  = (c_PTR_W+1)'(1);
    localparam logic [c_PTR_W:0] c_DEPTH    = (c_PTR_W+1)'(FIFO_DEPTH);
    localparam logic [4:0]      c_ADDR_DATA = 5'd0;
    localparam logic [4:0]      c_ADDR_EN   = 5'd4;
    localparam logic [4:0]      c_ADDR_MASK = 5'd8;
    localparam logic [4:0]      c_ADDR_POOL = 5'd12;
    localparam logic [4:0]      c_ADDR_ACK  = 5'd16;

    typedef enum logic [3:0] {
        INIT_EN   = 4'd0,
        INIT_MASK = 4'd1,
        INIT_POOL = 4'd2,
        IDLE      = 4'd3,
        RD_DATA   = 4'd4,
        WR_POOL   = 4'd5,
        WR_ACK    = 4'd6,
        SETTLE1   = 4'd7,
        SETTLE2   = 4'd8,
        CFG_EN    = 4'd9,
        CFG_MASK  = 4'd10,
        WR_OUT    = 4'd11
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         din_q, din_d;           // value captured in RD_DATA
    logic [31:0]         pool_q, pool_d;         // shadow of the slave pool register
    logic [31:0]         cfg_en_q, cfg_en_d;
    logic [31:0]         cfg_mask_q, cfg_mask_d;
    logic [31:0]         out_data_q, out_data_d;
    logic                ovf_q, ovf_d;
    logic [c_PTR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W:0]    rd_ptr_q, rd_ptr_d;
    logic [63:0]         fifo_mem_q [FIFO_DEPTH];

    logic [c_PTR_W:0]    w_count;
    logic                w_full;
    logic                w_push_req;
    logic                w_push_ok;
    logic                w_pop;
    logic                w_drop;
    logic [63:0]         w_push_word;
    logic [63:0]         w_head;

    assign w_count     = wr_ptr_q - rd_ptr_q;
    assign w_full      = (w_count == c_DEPTH);
    assign ev_valid    = (wr_ptr_q != rd_ptr_q);
    assign w_pop       = ev_valid & ev_ready;
    assign w_push_req  = (state_q == RD_DATA);
    // A full FIFO still accepts the push when the consumer frees a slot this cycle.
    assign w_push_ok   = w_push_req & (~w_full | w_pop);
    assign w_drop      = w_push_req & w_full & ~w_pop;
    assign w_push_word = {avm_readdata, avm_readdata ^ pool_q};
    assign w_head      = fifo_mem_q[rd_ptr_q[c_PTR_W-1:0]];
    // Head is masked when empty so the outputs read zero after reset/flush.
    assign ev_data     = ev_valid ? w_head[63:32] : 32'h0;
    assign ev_changed  = ev_valid ? w_head[31:0]  : 32'h0;
    assign ev_overflow = ovf_q;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= INIT_EN;
        else          state_q <= state_d;
    end

    // Next state, bus access decode and grant handshakes
    always_comb begin
        state_d       = state_q;
        avm_write     = 1'b0;
        avm_read      = 1'b0;
        avm_address   = c_ADDR_DATA;
        avm_writedata = 32'h0;
        cfg_ready     = 1'b0;
        out_ready     = 1'b0;
        case (state_q)
            INIT_EN:   begin avm_write = 1'b1; avm_address = c_ADDR_EN;   avm_writedata = ENABLE_INIT; state_d = INIT_MASK; end
            INIT_MASK: begin avm_write = 1'b1; avm_address = c_ADDR_MASK; avm_writedata = MASK_INIT;   state_d = INIT_POOL; end
            INIT_POOL: begin avm_write = 1'b1; avm_address = c_ADDR_POOL; avm_writedata = POOL_INIT;   state_d = IDLE;      end
            IDLE: begin
                // Interrupt service always wins; a persistent irq starves the others.
                if (gpio_irq) begin
                    state_d = RD_DATA;
                end else if (cfg_valid) begin
                    cfg_ready = 1'b1;
                    state_d   = CFG_EN;
                end else if (out_valid) begin
                    out_ready = 1'b1;
                    state_d   = WR_OUT;
                end
            end
            RD_DATA:  begin avm_read  = 1'b1; avm_address = c_ADDR_DATA;                              state_d = WR_POOL; end
            WR_POOL:  begin avm_write = 1'b1; avm_address = c_ADDR_POOL; avm_writedata = din_q;       state_d = WR_ACK;  end
            WR_ACK:   begin avm_write = 1'b1; avm_address = c_ADDR_ACK;  avm_writedata = 32'h1;       state_d = SETTLE1; end
            // The slave needs one cycle to register the ack and one more to drop irq.
            SETTLE1:  state_d = SETTLE2;
            SETTLE2:  state_d = IDLE;
            CFG_EN:   begin avm_write = 1'b1; avm_address = c_ADDR_EN;   avm_writedata = cfg_en_q;    state_d = CFG_MASK; end
            CFG_MASK: begin avm_write = 1'b1; avm_address = c_ADDR_MASK; avm_writedata = cfg_mask_q;  state_d = IDLE;     end
            WR_OUT:   begin avm_write = 1'b1; avm_address = c_ADDR_DATA; avm_writedata = out_data_q;  state_d = IDLE;     end
            default:  state_d = INIT_EN;
        endcase
        // Reset state is INIT_EN, so the bus must be forced quiet while reset is held.
        if (!reset_n) begin
            avm_write     = 1'b0;
            avm_read      = 1'b0;
            avm_address   = c_ADDR_DATA;
            avm_writedata = 32'h0;
            cfg_ready     = 1'b0;
            out_ready     = 1'b0;
        end
    end

    // Datapath next-state: captures, pool shadow, FIFO pointers, overflow flag
    always_comb begin
        din_d      = din_q;
        pool_d     = pool_q;
        cfg_en_d   = cfg_en_q;
        cfg_mask_d = cfg_mask_q;
        out_data_d = out_data_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        ovf_d      = ovf_q;
        if (state_q == RD_DATA)   din_d  = avm_readdata;
        if (state_q == INIT_POOL) pool_d = POOL_INIT;
        if (state_q == WR_POOL)   pool_d = din_q;
        if (cfg_ready) begin
            cfg_en_d   = cfg_enable;
            cfg_mask_d = cfg_mask;
        end
        if (out_ready) out_data_d = out_data;
        if (w_push_ok) wr_ptr_d = wr_ptr_q + c_PTR_ONE;
        if (w_pop)     rd_ptr_d = rd_ptr_q + c_PTR_ONE;
        // A drop in the same cycle as a clear keeps the flag set.
        if (w_drop)       ovf_d = 1'b1;
        else if (ovf_clr) ovf_d = 1'b0;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            din_q      <= 32'h0;
            pool_q     <= POOL_INIT;
            cfg_en_q   <= 32'h0;
            cfg_mask_q <= 32'h0;
            out_data_q <= 32'h0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ovf_q      <= 1'b0;
        end else begin
            din_q      <= din_d;
            pool_q     <= pool_d;
            cfg_en_q   <= cfg_en_d;
            cfg_mask_q <= cfg_mask_d;
            out_data_q <= out_data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ovf_q      <= ovf_d;
        end
    end

    // Event storage; contents are don't-care outside the pointer window
    always_ff @(posedge clk) begin
        if (w_push_ok) fifo_mem_q[wr_ptr_q[c_PTR_W-1:0]] <= w_push_word;
    end

endmodule
`default_nettype wire

// File: tb/tb_gpio_irq_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_irq_sequencer
// Description : Scoreboard bench: GPIO slave model, expected bus-access and
//               event queues, and a per-cycle FIFO/overflow reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_irq_sequencer;

    localparam int unsigned DEPTH   = 4;
    localparam logic [31:0] EN_INIT = 32'hFF;
    localparam logic [31:0] MK_INIT = 32'h0F;
    localparam logic [31:0] PL_INIT = 32'h0;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        avm_write, avm_read;
    logic [4:0]  avm_address;
    logic [31:0] avm_writedata, avm_readdata;
    logic        gpio_irq;
    logic        cfg_valid = 1'b0, cfg_ready;
    logic [31:0] cfg_enable = '0, cfg_mask = '0;
    logic        out_valid = 1'b0, out_ready;
    logic [31:0] out_data = '0;
    logic        ev_valid, ev_ready;
    logic [31:0] ev_data, ev_changed;
    logic        ev_overflow;
    logic        ovf_clr = 1'b0;

    // 0: never ready, 1: always ready, 2: random, 3: ready only during the read
    int          rdy_mode = 0;
    logic        ev_ready_r = 1'b0;
    assign ev_ready = (rdy_mode == 3) ? avm_read : ev_ready_r;

    gpio_irq_sequencer #(
        .FIFO_DEPTH (DEPTH),
        .ENABLE_INIT(EN_INIT),
        .MASK_INIT  (MK_INIT),
        .POOL_INIT  (PL_INIT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .avm_write    (avm_write),
        .avm_read     (avm_read),
        .avm_address  (avm_address),
        .avm_writedata(avm_writedata),
        .avm_readdata (avm_readdata),
        .gpio_irq     (gpio_irq),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_enable   (cfg_enable),
        .cfg_mask     (cfg_mask),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_data      (ev_data),
        .ev_changed   (ev_changed),
        .ev_overflow  (ev_overflow),
        .ovf_clr      (ovf_clr)
    );

    always #5 clk = ~clk;

    // ---------------- GPIO slave model ----------------
    logic [31:0] gpio_in = '0;
    logic [31:0] s_dout, s_en, s_mask, s_pool;
    logic        s_irq;
    assign avm_readdata = (avm_address == 5'd0)  ? gpio_in :
                          (avm_address == 5'd4)  ? s_en    :
                          (avm_address == 5'd8)  ? s_mask  :
                          (avm_address == 5'd12) ? s_pool  : 32'h0;
    assign gpio_irq = s_irq;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_dout <= '0; s_en <= '0; s_mask <= '0; s_pool <= '0; s_irq <= 1'b0;
        end else begin
            if (avm_write) begin
                case (avm_address)
                    5'd0:    s_dout <= avm_writedata;
                    5'd4:    s_en   <= avm_writedata;
                    5'd8:    s_mask <= avm_writedata;
                    5'd12:   s_pool <= avm_writedata;
                    default: ;
                endcase
            end
            s_irq <= |((gpio_in ^ s_pool) & s_mask);
        end
    end

    always @(posedge clk) begin
        #1;
        ev_ready_r = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    // ---------------- scoreboard ----------------
    typedef struct { bit wr; logic [4:0] addr; logic [31:0] data; } bus_t;
    typedef struct { logic [31:0] d; logic [31:0] c; } ev_t;
    bus_t exp_bus[$];
    ev_t  exp_cap[$];
    ev_t  mq[$];          // reference contents of the event FIFO
    bit   m_ovf = 1'b0;
    logic [31:0] m_pool = PL_INIT;
    logic [31:0] m_mask = MK_INIT;
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic exp_wr(input logic [4:0] a, input logic [31:0] d);
        bus_t b;
        b.wr = 1'b1; b.addr = a; b.data = d;
        exp_bus.push_back(b);
    endtask

    // Monitor: compares every bus access and the FIFO head each cycle
    always @(negedge clk) begin : mon
        bit   pop;
        bit   drop;
        bus_t b;
        ev_t  e;
        if (!reset_n) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            chk("ev_valid", ev_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("ev_data", ev_data, mq[0].d);
                chk("ev_changed", ev_changed, mq[0].c);
            end
            chk("ev_overflow", ev_overflow, m_ovf);
            pop = ev_ready && (mq.size() != 0);
            if (pop) void'(mq.pop_front());
            drop = 1'b0;
            if (avm_write || avm_read) begin
                if (exp_bus.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL bus_unexpected: got wr=%0b rd=%0b addr=%0d data=%h, expected no access",
                             avm_write, avm_read, avm_address, avm_writedata);
                end else begin
                    b = exp_bus.pop_front();
                    chk("bus_kind", {avm_write, avm_read}, {b.wr, ~b.wr});
                    chk("bus_addr", avm_address, b.addr);
                    if (b.wr) chk("bus_wdata", avm_writedata, b.data);
                    if (avm_read) begin
                        if (exp_cap.size() == 0) begin
                            tests++; fails++;
                            $display("FAIL cap_unexpected: got read at addr %0d, expected none", avm_address);
                        end else begin
                            e = exp_cap.pop_front();
                            if (mq.size() == DEPTH) drop = 1'b1;
                            else mq.push_back(e);
                        end
                    end
                end
            end
            if (drop)         m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic apply_reset();
        reset_n = 1'b0; gpio_in = '0; cfg_valid = 1'b0; out_valid = 1'b0; ovf_clr = 1'b0;
        exp_bus.delete(); exp_cap.delete();
        m_pool = PL_INIT; m_mask = MK_INIT;
        @(negedge clk); #2;
        chk("rst_bus", {avm_write, avm_read, avm_address, avm_writedata}, 64'h0);
        chk("rst_ready", {cfg_ready, out_ready}, 64'h0);
        chk("rst_ev_flags", {ev_valid, ev_overflow}, 64'h0);
        chk("rst_ev_data", {ev_data, ev_changed}, 64'h0);
        exp_wr(5'd4, EN_INIT); exp_wr(5'd8, MK_INIT); exp_wr(5'd12, PL_INIT);
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (3) @(negedge clk);
        #2 chk("init_in_3_cycles", exp_bus.size(), 0);
        @(negedge clk); #2;
        chk("idle_cycle3", {avm_write, avm_read}, 64'h0);
        chk("init_ev_valid", ev_valid, 1'b0);
    endtask

    task automatic push_irq(input logic [31:0] v_in);
        logic [31:0] v;
        bus_t b;
        ev_t  e;
        v = v_in;
        if (((v ^ m_pool) & m_mask) == 0) v = v ^ (m_mask & (~m_mask + 32'h1));
        b.wr = 1'b0; b.addr = 5'd0; b.data = '0;
        exp_bus.push_back(b);
        exp_wr(5'd12, v);
        e.d = v; e.c = v ^ m_pool;
        exp_cap.push_back(e);
        m_pool = v;
        gpio_in = v;
    endtask

    task automatic step(input bit do_irq, input logic [31:0] v_in,
                        input bit do_cfg, input logic [31:0] en, input logic [31:0] mk,
                        input bit do_out, input logic [31:0] od);
        int cfg_cnt = 0;
        int out_cnt = 0;
        bit cr, orr;
        int c;
        @(posedge clk); #1;
        if (do_irq) begin
            push_irq(v_in);
            exp_wr(5'd16, 32'h1);
        end
        @(posedge clk); #1;
        if (do_cfg) begin
            exp_wr(5'd4, en); exp_wr(5'd8, mk);
            m_mask = mk; cfg_enable = en; cfg_mask = mk; cfg_valid = 1'b1;
        end
        if (do_out) begin
            exp_wr(5'd0, od); out_data = od; out_valid = 1'b1;
        end
        for (c = 0; c < 80; c++) begin
            @(negedge clk);
            cr = cfg_ready; orr = out_ready;
            cfg_cnt += int'(cr); out_cnt += int'(orr);
            @(posedge clk); #1;
            if (cr)  cfg_valid = 1'b0;
            if (orr) out_valid = 1'b0;
            if (exp_bus.size() == 0 && !cfg_valid && !out_valid) break;
        end
        if (c == 80) begin
            tests++; fails++;
            $display("FAIL step_timeout: got %0d accesses outstanding, expected 0", exp_bus.size());
            exp_bus.delete(); exp_cap.delete(); cfg_valid = 1'b0; out_valid = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("cfg_ready_pulses", cfg_cnt, do_cfg);
        chk("out_ready_pulses", out_cnt, do_out);
    endtask

    task automatic irq_step();
        step(1'b1, $urandom, 1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic drain();
        rdy_mode = 1;
        for (int c = 0; c < 30; c++) begin
            if (mq.size() == 0) break;
            @(posedge clk);
        end
        @(negedge clk); #2;
        chk("drain_empty", ev_valid, 1'b0);
        rdy_mode = 0;
    endtask

    task automatic pulse_ovf_clr();
        @(posedge clk); #1 ovf_clr = 1'b1;
        @(posedge clk); #1 ovf_clr = 1'b0;
        @(negedge clk); #2;
        chk("ovf_cleared", ev_overflow, 1'b0);
    endtask

    task automatic reset_during_wr_pool();
        bit found = 1'b0;
        rdy_mode = 0;
        @(posedge clk); #1;
        push_irq(32'h0000_0009);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #2;
            if (avm_write && avm_address == 5'd12) begin
                found = 1'b1;
                break;
            end
        end
        chk("reached_wr_pool", found, 1'b1);
        apply_reset();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        apply_reset();

        // single change 0 -> 05
        rdy_mode = 0;
        step(1'b1, 32'h05, 1'b0, '0, '0, 1'b0, '0);
        chk("ev1_data", ev_data, 32'h05);
        chk("ev1_changed", ev_changed, 32'h05);
        drain();

        // irq, cfg and out requested together
        step(1'b1, $urandom, 1'b1, 32'h0F, 32'h03, 1'b1, $urandom);
        drain();

        // overflow: one more change than the FIFO holds
        rdy_mode = 0;
        repeat (DEPTH + 1) irq_step();
        chk("ovf_set", ev_overflow, 1'b1);
        pulse_ovf_clr();
        drain();

        // full FIFO with a pop coinciding with the capture
        rdy_mode = 0;
        repeat (DEPTH) irq_step();
        rdy_mode = 3;
        irq_step();
        rdy_mode = 0;
        chk("full_pop_no_ovf", ev_overflow, 1'b0);
        drain();

        // reset in the middle of a service
        reset_during_wr_pool();

        // randomized mix
        rdy_mode = 2;
        for (int i = 0; i < 30; i++) begin
            step(1'($urandom_range(0, 1)), $urandom,
                 1'($urandom_range(0, 1)), $urandom, $urandom | 32'h1,
                 1'($urandom_range(0, 1)), $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1 ovf_clr = 1'b1;
                @(posedge clk); #1 ovf_clr = 1'b0;
            end
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/gpio_irq_sequencer.md
# gpio_irq_sequencer

Avalon-MM master that owns the five-register programmable GPIO slave (data, enable, irq mask, irq pool, irq ack) and sequences all accesses to it. Programs the slave after reset and on configuration requests, forwards output-data writes, services the GPIO interrupt by capturing input data, re-arming the change-detect pool and acknowledging, and buffers captured input events in a FIFO for a downstream consumer. It sits between the GPIO slave and the rest of the fabric; nothing else masters that slave.

## Interface

- FIFO_DEPTH, 4: event FIFO entries (power of 2, ≥2)
- ENABLE_INIT, 32'h0: enable value programmed after reset
- MASK_INIT, 32'h0: irq mask programmed after reset
- POOL_INIT, 32'h0: irq pool programmed after reset

Ports:

- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- avm_write  out  1  slave write strobe
- avm_read  out  1  slave read strobe
- avm_address  out  5  slave byte address: 0 data, 4 enable, 8 mask, 12 pool, 16 ack
- avm_writedata  out  32  slave write data
- avm_readdata  in  32  slave read data, combinational from address, zero latency
- gpio_irq  in  1  slave interrupt, level
- cfg_valid / cfg_ready  in / out  1 / 1  reconfiguration handshake
- cfg_enable, cfg_mask  in  32 each  new enable / mask, held while cfg_valid
- out_valid / out_ready  in / out  1 / 1  output-data write handshake
- out_data  in  32  value for slave data register
- ev_valid / ev_ready  out / in  1 / 1  event FIFO read handshake
- ev_data  out  32  captured input value (FIFO head)
- ev_changed  out  32  captured value XOR previous pool (FIFO head)
- ev_overflow  out  1  sticky: an event was dropped
- ovf_clr  in  1  clears ev_overflow

## Operation

- States: INIT_EN, INIT_MASK, INIT_POOL, IDLE, RD_DATA, WR_POOL, WR_ACK, SETTLE1, SETTLE2, CFG_EN, CFG_MASK, WR_OUT. One bus access per state, one cycle per state; no waitrequest.
- Reset → INIT_EN. INIT_EN writes ENABLE_INIT @4, INIT_MASK writes MASK_INIT @8, INIT_POOL writes POOL_INIT @12 and loads pool_shadow = POOL_INIT → IDLE.
- IDLE arbitration, fixed priority: gpio_irq=1 → RD_DATA; else cfg_valid → CFG_EN (cfg_ready=1 this cycle, values latched); else out_valid → WR_OUT (out_ready=1, data latched). cfg_ready/out_ready are combinational, high only in the granting IDLE cycle.
- CFG_EN writes latched enable @4, CFG_MASK writes latched mask @8 → IDLE. Pool untouched.
- WR_OUT writes latched data @0 → IDLE.
- RD_DATA: avm_read=1, address 0; at cycle end capture d = avm_readdata, push {d, d ^ pool_shadow} into FIFO. If FIFO full and no pop this cycle: drop entry, set ev_overflow. Service continues regardless.
- WR_POOL writes d @12, pool_shadow ← d. WR_ACK writes 1 @16. SETTLE1, SETTLE2: no access (slave ack register then irq clear take one cycle each) → IDLE.
- Event FIFO: first-word-fall-through; ev_valid = not empty; pop on ev_valid & ev_ready. Push and pop same cycle when full: both succeed, count unchanged.
- ev_overflow: set has priority over ovf_clr in the same cycle.

## Timing

- Reset values: avm_write, avm_read, avm_address, avm_writedata = 0; cfg_ready, out_ready, ev_valid, ev_overflow = 0; ev_data, ev_changed = 0; FIFO empty; pool_shadow = POOL_INIT.
- avm_* outputs registered-state decoded, idle state drives read=write=0, address 0, writedata 0.
- Init: three writes in first three cycles after reset release; IDLE on cycle 3.
- Irq service: IDLE(irq seen) → 6 cycles to next IDLE; event visible on ev_valid the cycle after RD_DATA.
- If input changes between RD_DATA and WR_POOL, the slave re-raises irq; sequencer serves it again on return to IDLE (no event lost).
- cfg and out requests wait while an irq is pending; a persistent irq starves them (intended).
- reset_n asserted mid-sequence: immediate return to reset values, FIFO flushed, restart at INIT_EN.

## Test plan

- Reset with ENABLE_INIT=FF, MASK_INIT=0F, POOL_INIT=0 → writes FF@4, 0F@8, 0@12 in cycles 0-2, IDLE cycle 3, ev_valid=0.
- Slave input 0→05, irq raised → read @0 returns 05, event {05, 05}, write 05@12, write 1@16, irq low by IDLE, one event only.
- irq and cfg_valid (enable 0F, mask 03) and out_valid together → irq serviced first, then writes 0F@4, 03@8, then out_data@0; each ready pulses exactly one cycle.
- ev_ready=0, FIFO_DEPTH+1 input changes → first 4 events kept in order, ev_overflow=1, pool still written each time; ovf_clr clears it.
- Full FIFO with ev_ready=1 during RD_DATA → push and pop both succeed, no overflow.
- reset_n pulsed during WR_POOL → outputs 0, FIFO empty, init sequence reruns.
